// File: rtl/pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_if
// Description : Valid/ready handshake bundle for the upstream and downstream
//               sides of the elastic pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_reg_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : WIDTH-bit, DEPTH-stage elastic pipeline register with per-stage
//               valid, backpressure, bubble collapsing, flush and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       clr,
    pipe_reg_if.slave                       bus,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int            CW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             in_ready;
    logic             in_fire;
    logic             out_fire;

    // A stage is ready when any stage from it to the output is empty, or
    // the consumer is taking the last word (flattened form of the ready chain).
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign rdy[i] = bus.out_ready | ~(&v_q[DEPTH-1:i]);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_src
        if (i == 0) begin : g_head
            assign src_v[i] = bus.in_valid;
            assign src_d[i] = bus.in_data;
        end else begin : g_body
            assign src_v[i] = v_q[i-1];
            assign src_d[i] = data_q[i-1];
        end
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                v_d[i] = src_v[i];
                // A bubble moving in clears valid but keeps the old data.
                if (src_v[i]) begin
                    data_d[i] = src_d[i];
                end
            end
        end
    end

    assign in_ready      = rdy[0] & ~clr;
    assign in_fire       = bus.in_valid & in_ready;
    assign out_fire      = v_q[DEPTH-1] & bus.out_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign count         = count_q;

    always_comb begin
        count_d = count_q;
        case ({in_fire, out_fire})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
        end else if (clr) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
        end else begin
            v_q     <= v_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg
// Description : Drives a DEPTH=3 and a DEPTH=2 pipe_reg from shared stimulus and
//               compares both against a word-position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv    = 1'b0;
    logic       orr   = 1'b0;
    logic       cl    = 1'b0;
    logic [7:0] id    = 8'h00;

    always #5 clk = ~clk;

    pipe_reg_if #(.WIDTH(8)) bus3 ();
    pipe_reg_if #(.WIDTH(8)) bus2 ();

    assign bus3.in_valid  = iv;
    assign bus3.in_data   = id;
    assign bus3.out_ready = orr;
    assign bus2.in_valid  = iv;
    assign bus2.in_data   = id;
    assign bus2.out_ready = orr;

    logic [1:0] count3;
    logic [1:0] count2;

    pipe_reg #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h5A)) dut3 (
        .clk(clk), .rst_n(rst_n), .clr(cl), .bus(bus3), .count(count3)
    );
    pipe_reg #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'hC3)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(cl), .bus(bus2), .count(count2)
    );

    // {out_valid, in_ready, count, out_data}
    logic [11:0] act [2];
    assign act[0] = {bus3.out_valid, bus3.in_ready, count3, bus3.out_data};
    assign act[1] = {bus2.out_valid, bus2.in_ready, count2, bus2.out_data};

    int checks = 0;
    int errors = 0;

    // Reference: each pipe holds an ordered list of words (oldest first), each
    // with the stage index it occupies; out_data is the last word to reach the end.
    int         mn    [2];
    int         mpos  [2][4];
    logic [7:0] mdat  [2][4];
    logic [7:0] mlast [2];

    function automatic int dep(int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic logic [7:0] rv(int k);
        return (k == 0) ? 8'h5A : 8'hC3;
    endfunction

    // Position word j occupies after the next edge: it advances one stage if
    // the stage ahead is free once the older words have moved.
    function automatic int np_of(int k, int j, logic r);
        int d = dep(k);
        int np = 0;
        for (int t = 0; t <= j; t++) begin
            if (t == 0)
                np = (mpos[k][0] == d - 1) ? (r ? d : d - 1) : mpos[k][0] + 1;
            else
                np = (mpos[k][t] + 1 < np - 1) ? mpos[k][t] + 1 : np - 1;
        end
        return np;
    endfunction

    function automatic logic m_ready(int k, logic r);
        if (mn[k] == 0) return 1'b1;
        return np_of(k, mn[k] - 1, r) > 0;
    endfunction

    function automatic logic [11:0] expv(int k);
        logic ov = (mn[k] > 0) && (mpos[k][0] == dep(k) - 1);
        return {ov, m_ready(k, orr) & ~cl, 2'(mn[k]), mlast[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mn[k]    = 0;
            mlast[k] = rv(k);
        end
    endtask

    task automatic model_step(int k);
        int d = dep(k);
        int np [4];
        int w = 0;
        logic acc;
        if (cl) begin
            mn[k]    = 0;
            mlast[k] = rv(k);
        end else begin
            acc = iv && m_ready(k, orr);
            for (int j = 0; j < mn[k]; j++) np[j] = np_of(k, j, orr);
            for (int j = 0; j < mn[k]; j++) begin
                if (np[j] < d) begin
                    if (np[j] == d - 1 && mpos[k][j] != d - 1) mlast[k] = mdat[k][j];
                    mpos[k][w] = np[j];
                    mdat[k][w] = mdat[k][j];
                    w++;
                end
            end
            if (acc) begin
                mpos[k][w] = 0;
                mdat[k][w] = id;
                if (d == 1) mlast[k] = id;
                w++;
            end
            mn[k] = w;
        end
    endtask

    task automatic drive(logic v, logic [7:0] d, logic r, logic c);
        iv  = v;
        id  = d;
        orr = r;
        cl  = c;
        #1;
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        drive(0, 8'h00, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act[k] !== expv(k)) begin
                errors++;
                $display("FAIL reset dut%0d: got %h expected %h", k, act[k], expv(k));
            end
        end
        rst_n = 1'b1;
        drive(1, 8'h31, 0, 0); tick();
        drive(1, 8'h32, 0, 0); tick();
        drive(0, 8'h00, 0, 0);
        checks++;
        if (count3 !== 2'd2 || count2 !== 2'd2) begin
            errors++;
            $display("FAIL prefill_count: got %0d/%0d expected 2/2", count3, count2);
        end
        model_step(0);
        model_step(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act[k] !== expv(k)) begin
                errors++;
                $display("FAIL async_reset dut%0d: got %h expected %h", k, act[k], expv(k));
            end
        end
        checks++;
        if (bus3.out_valid !== 1'b0 || count3 !== 2'd0 || bus3.out_data !== 8'h5A) begin
            errors++;
            $display("FAIL async_reset_dut3: got v=%b c=%0d d=%h expected v=0 c=0 d=5a",
                     bus3.out_valid, count3, bus3.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int ec [4] = '{1, 1, 1, 0};
        drive(1, 8'hA5, 1, 0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(0, 8'h00, 1, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== expv(k)) begin
                    errors++;
                    $display("FAIL latency dut%0d c%0d: got %h expected %h", k, c, act[k], expv(k));
                end
            end
            checks++;
            if (bus3.out_valid !== (c == 3) || count3 !== 2'(ec[c-1]) ||
                (c == 3 && bus3.out_data !== 8'hA5)) begin
                errors++;
                $display("FAIL latency_dut3 c%0d: got v=%b c=%0d d=%h expected v=%0d c=%0d",
                         c, bus3.out_valid, count3, bus3.out_data, c == 3, ec[c-1]);
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        logic [7:0] got [$];
        for (int c = 0; c < 20; c++) begin
            drive(c < 16, 8'(c + 1), 1, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== expv(k)) begin
                    errors++;
                    $display("FAIL stream dut%0d c%0d: got %h expected %h", k, c, act[k], expv(k));
                end
            end
            checks++;
            if (bus3.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready c%0d: got %b expected 1", c, bus3.in_ready);
            end
            if (bus3.out_valid === 1'b1) got.push_back(bus3.out_data);
            tick();
        end
        checks++;
        if (got.size() != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d words expected 16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL stream_order %0d: got %h expected %h", i, got[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q   [$] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] got [$];
        logic acc;
        for (int c = 0; c < 14; c++) begin
            drive(q.size() > 0, (q.size() > 0) ? q[0] : 8'h00, c >= 6, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== expv(k)) begin
                    errors++;
                    $display("FAIL backpressure dut%0d c%0d: got %h expected %h", k, c, act[k], expv(k));
                end
            end
            if (c == 5) begin
                checks++;
                if (count2 !== 2'd2 || bus2.in_ready !== 1'b0 || bus2.out_data !== 8'h11) begin
                    errors++;
                    $display("FAIL stall_dut2: got c=%0d rdy=%b d=%h expected c=2 rdy=0 d=11",
                             count2, bus2.in_ready, bus2.out_data);
                end
            end
            if (bus2.out_valid === 1'b1 && orr) got.push_back(bus2.out_data);
            acc = iv && bus2.in_ready;
            tick();
            if (acc) void'(q.pop_front());
        end
        checks++;
        if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
            errors++;
            $display("FAIL backpressure_order: got %0d words %p expected 11 22 33", got.size(), got);
        end
    endtask

    task automatic test_full_simul();
        for (int c = 0; c < 3; c++) begin
            drive(1, 8'($urandom), 0, 0);
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1, 8'($urandom), 1, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== expv(k)) begin
                    errors++;
                    $display("FAIL full_simul dut%0d c%0d: got %h expected %h", k, c, act[k], expv(k));
                end
            end
            checks++;
            if (count3 !== 2'd3 || count2 !== 2'd2 || bus3.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_simul_state c%0d: got c=%0d/%0d rdy=%b/%b expected 3/2 1/1",
                         c, count3, count2, bus3.in_ready, bus2.in_ready);
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, 8'h00, 1, 0);
            tick();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 2; c++) begin
            drive(1, 8'(8'h10 + $urandom_range(0, 63)), 0, 0);
            tick();
        end
        drive(1, 8'h77, 0, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act[k] !== expv(k)) begin
                errors++;
                $display("FAIL flush dut%0d: got %h expected %h", k, act[k], expv(k));
            end
        end
        checks++;
        if (bus3.in_ready !== 1'b0 || bus2.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b/%b expected 0/0", bus3.in_ready, bus2.in_ready);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(0, 8'h00, 1, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== expv(k)) begin
                    errors++;
                    $display("FAIL post_flush dut%0d c%0d: got %h expected %h", k, c, act[k], expv(k));
                end
            end
            checks++;
            if ((c == 0 && (count3 !== 2'd0 || bus3.out_valid !== 1'b0)) ||
                (bus3.out_valid === 1'b1 && bus3.out_data === 8'h77)) begin
                errors++;
                $display("FAIL post_flush_dut3 c%0d: got c=%0d v=%b d=%h expected c=0 v=0 and no 77",
                         c, count3, bus3.out_valid, bus3.out_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== expv(k)) begin
                    errors++;
                    $display("FAIL random dut%0d c%0d: got %h expected %h", k, c, act[k], expv(k));
                end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_full_simul();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1);
    end

endmodule
`default_nettype wire
